// File: rtl/stream_checker_pkg.sv
// Shared types and helpers for the stream_checker sink: stall modes, FSM states
// and the backpressure LFSR step function.
package stream_checker_pkg;

    typedef enum logic [1:0] {
        MODE_ALWAYS  = 2'd0,
        MODE_NEVER   = 2'd1,
        MODE_RANDOM  = 2'd2,
        MODE_PATTERN = 2'd3
    } stall_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Fibonacci LFSR, taps 16/14/13/11, shifting right with feedback into bit 15.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/stream_checker_lfsr16.sv
// 16-bit backpressure LFSR: synchronous load has priority over advance.
module lfsr16
    import stream_checker_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        advance_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (advance_i) begin
            state_d = lfsr16_next(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/stream_checker.sv
// Receive-side stream sink: programmable backpressure, incrementing-payload check,
// handshake protocol monitor, beat/error counters and pass/fail reporting.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [WIDTH-1:0] start_value,
    input  logic [CNT_W-1:0] expected_count,
    input  logic [1:0]       stall_mode,
    input  logic [7:0]       stall_pattern,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] err_count,
    output logic             proto_err,
    output logic [WIDTH-1:0] first_err_got,
    output logic [WIDTH-1:0] first_err_exp
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIDTH-1:0] EXP_ONE = WIDTH'(1);

    state_e            state_q,   state_d;
    stall_mode_e       mode_q,    mode_d;
    logic [7:0]        pat_q,     pat_d;
    logic [CNT_W-1:0]  target_q,  target_d;
    logic [CNT_W-1:0]  beat_q,    beat_d;
    logic [CNT_W-1:0]  err_q,     err_d;
    logic [WIDTH-1:0]  exp_q,     exp_d;
    logic [WIDTH-1:0]  fgot_q,    fgot_d;
    logic [WIDTH-1:0]  fexp_q,    fexp_d;
    logic [WIDTH-1:0]  held_q,    held_d;
    logic              stalled_q, stalled_d;
    logic              proto_q,   proto_d;
    logic              ready_q,   ready_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              pass_q,    pass_d;

    logic              start_ok;
    logic              handshake;
    logic              lfsr_adv;
    logic [15:0]       lfsr_state;
    logic [15:0]       lfsr_nx;

    assign start_ok  = start && (state_q != ST_RUN);
    assign handshake = (state_q == ST_RUN) && valid_in && ready_q;
    assign lfsr_adv  = (state_q == ST_RUN);

    lfsr16 u_lfsr (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (start_ok),
        .seed_i    (LFSR_SEED),
        .advance_i (lfsr_adv),
        .state_o   (lfsr_state)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pat_d     = pat_q;
        target_d  = target_q;
        beat_d    = beat_q;
        err_d     = err_q;
        exp_d     = exp_q;
        fgot_d    = fgot_q;
        fexp_d    = fexp_q;
        held_d    = data_in;
        stalled_d = 1'b0;
        proto_d   = proto_q;
        ready_d   = 1'b0;
        lfsr_nx   = lfsr16_next(lfsr_state);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    exp_d    = start_value;
                    beat_d   = '0;
                    err_d    = '0;
                    proto_d  = 1'b0;
                    fgot_d   = '0;
                    fexp_d   = '0;
                    mode_d   = stall_mode_e'(stall_mode);
                    pat_d    = stall_pattern;
                    target_d = expected_count;
                    state_d  = (expected_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                stalled_d = valid_in && !ready_q;
                pat_d     = {pat_q[0], pat_q[7:1]};
                // A stall seen on the previous edge obliges upstream to hold valid and data.
                if (stalled_q && (!valid_in || (data_in != held_q))) begin
                    proto_d = 1'b1;
                end
                if (handshake) begin
                    beat_d = beat_q + CNT_ONE;
                    exp_d  = exp_q + EXP_ONE;
                    if (data_in != exp_q) begin
                        if (err_q == '0) begin
                            fgot_d = data_in;
                            fexp_d = exp_q;
                        end
                        if (err_q != '1) begin
                            err_d = err_q + CNT_ONE;
                        end
                    end
                    if ((beat_q + CNT_ONE) == target_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ready_in is the registered image of the LFSR / pattern bit the next cycle will see.
        if (state_d == ST_RUN) begin
            unique case (mode_d)
                MODE_ALWAYS:  ready_d = 1'b1;
                MODE_NEVER:   ready_d = 1'b0;
                MODE_RANDOM:  ready_d = start_ok ? LFSR_SEED[0] : lfsr_nx[0];
                MODE_PATTERN: ready_d = pat_d[0];
                default:      ready_d = 1'b0;
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == '0) && !proto_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ALWAYS;
            pat_q     <= '0;
            target_q  <= '0;
            beat_q    <= '0;
            err_q     <= '0;
            exp_q     <= '0;
            fgot_q    <= '0;
            fexp_q    <= '0;
            held_q    <= '0;
            stalled_q <= 1'b0;
            proto_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pat_q     <= pat_d;
            target_q  <= target_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            exp_q     <= exp_d;
            fgot_q    <= fgot_d;
            fexp_q    <= fexp_d;
            held_q    <= held_d;
            stalled_q <= stalled_d;
            proto_q   <= proto_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign ready_in      = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign beat_count    = beat_q;
    assign err_count     = err_q;
    assign proto_err     = proto_q;
    assign first_err_got = fgot_q;
    assign first_err_exp = fexp_q;

endmodule

// File: tb/tb_stream_checker.sv
// Self-checking bench for stream_checker: table-driven stream runs plus directed
// protocol, zero-count and LFSR reset/replay sequences.
module tb_stream_checker;

    localparam int REC_N = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [15:0] data_in = '0;
    logic        start = 1'b0;
    logic [15:0] start_value = '0;
    logic [31:0] expected_count = '0;
    logic [1:0]  stall_mode = '0;
    logic [7:0]  stall_pattern = '0;
    logic        busy, done, pass, proto_err;
    logic [31:0] beat_count, err_count;
    logic [15:0] first_err_got, first_err_exp;

    int checks = 0;
    int errors = 0;
    logic rec_buf [2][REC_N];

    stream_checker dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .data_in        (data_in),
        .start          (start),
        .start_value    (start_value),
        .expected_count (expected_count),
        .stall_mode     (stall_mode),
        .stall_pattern  (stall_pattern),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .beat_count     (beat_count),
        .err_count      (err_count),
        .proto_err      (proto_err),
        .first_err_got  (first_err_got),
        .first_err_exp  (first_err_exp)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  pat;
        logic [15:0] sv;
        int          n;
        int          skip;
        int          exp_cyc;
        logic [31:0] exp_err;
        logic        exp_pass;
        logic [15:0] fgot;
        logic [15:0] fexp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] mode, input logic [7:0] pat,
                            input logic [15:0] sv, input logic [31:0] cnt);
        stall_mode     = mode;
        stall_pattern  = pat;
        start_value    = sv;
        expected_count = cnt;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    function automatic logic [15:0] beat_data(input logic [15:0] base, input int i, input int skip);
        logic [15:0] d;
        d = base + 16'(i);
        if (skip >= 0 && i >= skip) d = d + 16'd1;
        return d;
    endfunction

    // Upstream source: holds valid/data until accepted, optional ready trace recording.
    task automatic run_stream(input logic [15:0] base, input int n, input int skip,
                              input int budget, input bit rec, input int slot,
                              output int last_cyc, output int hs_n);
        int  cyc;
        logic hs;
        cyc = 0;
        hs_n = 0;
        last_cyc = -1;
        valid_in = 1'b1;
        data_in = beat_data(base, 0, skip);
        while (hs_n < n && cyc < budget) begin
            if (rec && cyc < REC_N) rec_buf[slot][cyc] = ready_in;
            hs = ready_in;
            tick();
            cyc++;
            if (hs) begin
                hs_n++;
                last_cyc = cyc;
                if (hs_n < n) data_in = beat_data(base, hs_n, skip);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_ready", 32'(ready_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_beat", beat_count, 32'd0);
        #2 reset = 1'b1;
        tick();
    endtask

    initial begin
        vec_t vecs[5];
        int last_cyc, hs_n, mism;
        logic [15:0] m;

        vecs[0] = '{2'd0, 8'h00, 16'h0000, 8,  -1, 8,  32'd0, 1'b1, 16'h0000, 16'h0000};
        vecs[1] = '{2'd3, 8'h55, 16'h0100, 10, -1, 19, 32'd0, 1'b1, 16'h0000, 16'h0000};
        vecs[2] = '{2'd0, 8'h00, 16'h0200, 4,  2,  4,  32'd2, 1'b0, 16'h0203, 16'h0202};
        vecs[3] = '{2'd0, 8'h00, 16'hFFFE, 4,  -1, 4,  32'd0, 1'b1, 16'h0000, 16'h0000};
        vecs[4] = '{2'd3, 8'h03, 16'h0010, 4,  -1, 10, 32'd0, 1'b1, 16'h0000, 16'h0000};

        #3;
        check("reset_ready", 32'(ready_in), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_proto", 32'(proto_err), 32'd0);
        check("reset_beat", beat_count, 32'd0);
        check("reset_err", err_count, 32'd0);
        check("reset_fgot", 32'(first_err_got), 32'd0);
        #4 reset = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            do_start(vecs[v].mode, vecs[v].pat, vecs[v].sv, 32'(vecs[v].n));
            check($sformatf("v%0d_busy_arm", v), 32'(busy), 32'd1);
            check($sformatf("v%0d_ready_arm", v), 32'(ready_in),
                  (vecs[v].mode == 2'd0) ? 32'd1 : 32'(vecs[v].pat[0]));
            run_stream(vecs[v].sv, vecs[v].n, vecs[v].skip, 200, 1'b0, 0, last_cyc, hs_n);
            check($sformatf("v%0d_hs", v), 32'(hs_n), 32'(vecs[v].n));
            check($sformatf("v%0d_cycles", v), 32'(last_cyc), 32'(vecs[v].exp_cyc));
            check($sformatf("v%0d_done", v), 32'(done), 32'd1);
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_ready", v), 32'(ready_in), 32'd0);
            check($sformatf("v%0d_pass", v), 32'(pass), 32'(vecs[v].exp_pass));
            check($sformatf("v%0d_beat", v), beat_count, 32'(vecs[v].n));
            check($sformatf("v%0d_err", v), err_count, vecs[v].exp_err);
            check($sformatf("v%0d_fgot", v), 32'(first_err_got), 32'(vecs[v].fgot));
            check($sformatf("v%0d_fexp", v), 32'(first_err_exp), 32'(vecs[v].fexp));
            valid_in = 1'b1;
            data_in = 16'h7777;
            tick();
            tick();
            valid_in = 1'b0;
            check($sformatf("v%0d_no_extra", v), beat_count, 32'(vecs[v].n));
        end

        // Never-ready: valid withdrawn while stalled; start in RUN ignored.
        do_start(2'd1, 8'h00, 16'h0000, 32'd5);
        check("never_ready", 32'(ready_in), 32'd0);
        stall_mode = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run_ignored", 32'(ready_in), 32'd0);
        valid_in = 1'b1;
        data_in = 16'h0055;
        tick();
        tick();
        check("proto_hold_ok", 32'(proto_err), 32'd0);
        valid_in = 1'b0;
        tick();
        check("proto_withdraw", 32'(proto_err), 32'd1);
        check("proto_beat", beat_count, 32'd0);
        check("proto_busy", 32'(busy), 32'd1);
        pulse_reset();
        check("proto_cleared_by_reset", 32'(proto_err), 32'd0);

        // Never-ready: data changed while stalled.
        do_start(2'd1, 8'h00, 16'h0000, 32'd5);
        valid_in = 1'b1;
        data_in = 16'h1234;
        tick();
        tick();
        data_in = 16'h1235;
        tick();
        check("proto_data_change", 32'(proto_err), 32'd1);
        valid_in = 1'b0;
        pulse_reset();

        do_start(2'd0, 8'h00, 16'h0000, 32'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_ready", 32'(ready_in), 32'd0);
        check("zero_pass", 32'(pass), 32'd1);

        // LFSR backpressure: abort mid-run with reset, then replay from the seed.
        do_start(2'd2, 8'h00, 16'h0000, 32'd60);
        run_stream(16'h0000, 60, -1, REC_N, 1'b1, 0, last_cyc, hs_n);
        mism = 0;
        m = 16'hACE1;
        for (int k = 0; k < REC_N; k++) begin
            if (rec_buf[0][k] !== m[0]) mism++;
            m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        end
        check("lfsr_seq_model", 32'(mism), 32'd0);
        pulse_reset();

        do_start(2'd2, 8'h00, 16'h0000, 32'd60);
        run_stream(16'h0000, 60, -1, 1000, 1'b1, 1, last_cyc, hs_n);
        mism = 0;
        for (int k = 0; k < REC_N; k++) begin
            if (rec_buf[1][k] !== rec_buf[0][k]) mism++;
        end
        check("lfsr_replay", 32'(mism), 32'd0);
        check("lfsr_hs", 32'(hs_n), 32'd60);
        check("lfsr_done", 32'(done), 32'd1);
        check("lfsr_pass", 32'(pass), 32'd1);
        check("lfsr_beat", beat_count, 32'd60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_checker.md
# stream_checker

Synthesizable receive-side endpoint for the valid/ready stream protocol used by the skid-buffer pipeline. It consumes a stream, applies programmable backpressure (always, never, pseudo-random, or patterned) on `ready_in`, and checks that payloads arrive as an incrementing sequence. It also flags handshake-protocol violations and reports counts and pass/fail. It sits at the tail of a skid-buffer chain for on-chip self-test, and serves as the reusable sink model for stream benches.

## Interface
- `WIDTH`, 16: payload width in bits.
- `CNT_W`, 32: width of the beat and error counters.
- `LFSR_SEED`, 16'hACE1: non-zero seed loaded into the backpressure LFSR on `start`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `valid_in`  in  1: upstream payload valid.
- `ready_in`  out  WIDTH-independent 1: registered ready to upstream; never depends combinationally on `valid_in` or `data_in`.
- `data_in`  in  WIDTH: upstream payload.
- `start`  in  1: one-cycle arm pulse; honoured only in IDLE or DONE.
- `start_value`  in  WIDTH: first expected payload, sampled on `start`.
- `expected_count`  in  CNT_W: number of beats to consume, sampled on `start`.
- `stall_mode`  in  2: 0 = always ready, 1 = never ready, 2 = LFSR random, 3 = pattern. Sampled on `start`.
- `stall_pattern`  in  8: ready pattern for mode 3, sampled on `start`.
- `busy`  out  1: state is RUN.
- `done`  out  1: state is DONE.
- `pass`  out  1: `done` && `err_count` == 0 && !`proto_err`.
- `beat_count`  out  CNT_W: handshakes accepted in the current run.
- `err_count`  out  CNT_W: data mismatches; saturates at all-ones.
- `proto_err`  out  1: sticky protocol-violation flag.
- `first_err_got` / `first_err_exp`  out  WIDTH each: payload and expected value captured at the first mismatch.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - Reset enters IDLE.
  - IDLE or DONE + `start` → RUN, or → DONE directly if `expected_count` == 0.
  - RUN → DONE on the handshake where `beat_count` + 1 == `expected_count`.
  - `start` while in RUN is ignored.
- **On an accepted `start`:**
  - `exp` ← `start_value`.
  - `beat_count`, `err_count`, `proto_err` and the first-error registers clear.
  - LFSR ← `LFSR_SEED`; pattern register ← `stall_pattern`.
- **Handshake:** a handshake occurs when `valid_in` && `ready_in` at a rising edge in RUN. On each handshake:
  - `beat_count` increments.
  - `exp` ← `exp` + 1, modulo 2^WIDTH (so FFFF wraps to 0000). `exp` always advances from the expected value, never from `data_in`.
  - If `data_in` != `exp`, `err_count` increments (saturating). If this is the first mismatch of the run, `data_in` and `exp` are captured.
- **Backpressure:** `ready_in` is registered and is 0 whenever the next state is not RUN. In RUN:
  - mode 0: 1.
  - mode 1: 0.
  - mode 2: LFSR bit 0. The LFSR is a 16-bit Fibonacci LFSR with taps 16, 14, 13, 11 and advances every RUN cycle.
  - mode 3: pattern bit 0. The pattern register rotates right one bit every RUN cycle.
- **Protocol check (RUN only):** `proto_err` is set if either of the following holds at a rising edge:
  - `valid_in` was high with `ready_in` low on the previous edge and `valid_in` is now low (valid withdrawn while stalled).
  - The same stall condition held and `data_in` has changed (data not held stable).
- **Outside RUN:** `valid_in` is ignored.

## Timing
- **Reset values:** `ready_in`, `busy`, `done`, `pass`, `proto_err` = 0; all counters and capture registers = 0.
- **Arm latency:** `start` at edge N gives `busy` = 1 and `ready_in` valid per mode at N+1.
- **Completion:** after the final handshake at edge N, `done` = 1 and `ready_in` = 0 at N+1. The block never accepts an extra beat.
- **Count visibility:** counters reflect a handshake in the cycle after it.
- **Reset mid-run:** asynchronous return to IDLE; all outputs take their reset values immediately.

## Structure
- Shared package holds `stall_mode_e` (ALWAYS, NEVER, RANDOM, PATTERN) and the FSM state enum.
- One sub-module, `lfsr16`, with ports: load, seed, advance, and a 16-bit state output.

## Test plan
- Mode 0, `start_value` = 0000, `expected_count` = 8, upstream sends 0000..0007 back-to-back → 8 handshakes on 8 consecutive edges, `pass` = 1, `err_count` = 0.
- Mode 3, `stall_pattern` = 8'b0101_0101, 10 beats from 0100 → handshakes on alternate cycles only, `beat_count` = 10, `pass` = 1.
- Stream 0200, 0201, 0203, 0204 against `expected_count` = 4 → `err_count` = 2, `first_err_got` = 0203, `first_err_exp` = 0202, `pass` = 0.
- `start_value` = FFFE, 4 beats FFFE, FFFF, 0000, 0001 → `pass` = 1 (wrap-around accepted).
- Mode 1 with `valid_in` raised then dropped after 2 cycles → `proto_err` = 1, `beat_count` = 0. `expected_count` = 0 → `done` one cycle after `start`.
- Mode 2 with 60 beats, then assert `reset` mid-run → `ready_in` and `busy` go to 0 immediately. Re-`start` and rerun → same `ready_in` sequence as the first run (seeded LFSR), `pass` = 1.
